// File: rtl/time_set_ctrl_if.sv
// Key/count inputs and control/alarm outputs of the clock time-set controller.
interface time_set_ctrl_if;
    logic [3:0] Key_pulse;
    logic [5:0] count_S;
    logic [5:0] count_M;
    logic [4:0] count_H;
    logic       Add_S;
    logic       Add_M;
    logic       Add_H;
    logic       Subtract_S;
    logic       Subtract_M;
    logic       Subtract_H;
    logic       Run_en;
    logic [1:0] Mode;
    logic [1:0] Field;
    logic [5:0] Alarm_S;
    logic [5:0] Alarm_M;
    logic [4:0] Alarm_H;
    logic       Alarm_en;
    logic       Alarm_match;

    modport master (
        output Key_pulse, count_S, count_M, count_H,
        input  Add_S, Add_M, Add_H, Subtract_S, Subtract_M, Subtract_H,
        input  Run_en, Mode, Field, Alarm_S, Alarm_M, Alarm_H, Alarm_en, Alarm_match
    );

    modport slave (
        input  Key_pulse, count_S, count_M, count_H,
        output Add_S, Add_M, Add_H, Subtract_S, Subtract_M, Subtract_H,
        output Run_en, Mode, Field, Alarm_S, Alarm_M, Alarm_H, Alarm_en, Alarm_match
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Time/alarm setting controller: walks RUN -> SET_TIME -> SET_ALARM on MODE,
// strobes the time counters while setting time, edits a stored alarm time,
// auto-exits idle edits and raises a registered alarm match level.
module time_set_ctrl #(
    parameter int TIMEOUT_CYC = 500_000_000
) (
    input logic           Clk_50MHz,
    input logic           Reset_N,
    time_set_ctrl_if.slave bus
);

    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_e;

    mode_e             mode_q, mode_d;
    field_e            field_q, field_d;
    logic [5:0]        alarm_s_q, alarm_s_d;
    logic [5:0]        alarm_m_q, alarm_m_d;
    logic [4:0]        alarm_h_q, alarm_h_d;
    logic              alarm_en_q, alarm_en_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [2:0]        add_q, add_d;
    logic [2:0]        sub_q, sub_d;
    logic              run_en_q, run_en_d;
    logic              match_q, match_d;

    logic key_mode, key_sel, key_up, key_down;
    logic [2:0] field_onehot;

    // Only the highest-priority key of a cycle survives: MODE > SELECT > UP > DOWN.
    assign key_mode = bus.Key_pulse[0];
    assign key_sel  = bus.Key_pulse[1] & ~bus.Key_pulse[0];
    assign key_up   = bus.Key_pulse[2] & ~(|bus.Key_pulse[1:0]);
    assign key_down = bus.Key_pulse[3] & ~(|bus.Key_pulse[2:0]);

    function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
        return (v >= max) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] max);
        return (v == 6'd0 || v > max) ? max : v - 6'd1;
    endfunction

    // Field selection as a one-hot strobe pattern {HOUR, MIN, SEC}.
    always_comb begin
        field_onehot = 3'b000;
        case (field_q)
            FIELD_SEC:  field_onehot = 3'b001;
            FIELD_MIN:  field_onehot = 3'b010;
            default:    field_onehot = 3'b100;
        endcase
    end

    // Next-state logic: key handling in priority order, then the idle timeout.
    always_comb begin
        mode_d     = mode_q;
        field_d    = field_q;
        alarm_s_d  = alarm_s_q;
        alarm_m_d  = alarm_m_q;
        alarm_h_d  = alarm_h_q;
        alarm_en_d = alarm_en_q;
        idle_d     = idle_q;
        add_d      = 3'b000;
        sub_d      = 3'b000;

        if (key_mode) begin
            idle_d  = '0;
            field_d = FIELD_SEC;
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_TIME;
                MODE_SET_TIME: mode_d = MODE_SET_ALARM;
                default:       mode_d = MODE_RUN;
            endcase
        end else if (key_sel) begin
            idle_d = '0;
            if (mode_q == MODE_RUN) begin
                alarm_en_d = ~alarm_en_q;
            end else begin
                case (field_q)
                    FIELD_SEC: field_d = FIELD_MIN;
                    FIELD_MIN: field_d = FIELD_HOUR;
                    default:   field_d = FIELD_SEC;
                endcase
            end
        end else if (key_up || key_down) begin
            idle_d = '0;
            if (mode_q == MODE_SET_TIME) begin
                add_d = key_up   ? field_onehot : 3'b000;
                sub_d = key_down ? field_onehot : 3'b000;
            end else if (mode_q == MODE_SET_ALARM) begin
                case (field_q)
                    FIELD_SEC:
                        alarm_s_d = key_up ? wrap_inc(alarm_s_q, 6'd59) : wrap_dec(alarm_s_q, 6'd59);
                    FIELD_MIN:
                        alarm_m_d = key_up ? wrap_inc(alarm_m_q, 6'd59) : wrap_dec(alarm_m_q, 6'd59);
                    default:
                        alarm_h_d = key_up ? 5'(wrap_inc({1'b0, alarm_h_q}, 6'd23))
                                           : 5'(wrap_dec({1'b0, alarm_h_q}, 6'd23));
                endcase
            end
        end else if (mode_q != MODE_RUN) begin
            if (idle_q == IDLE_LAST) begin
                mode_d  = MODE_RUN;
                field_d = FIELD_SEC;
                idle_d  = '0;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end else begin
            idle_d = '0;
        end

        run_en_d = (mode_d != MODE_SET_TIME);
        match_d  = alarm_en_q && (mode_q != MODE_SET_ALARM) &&
                   (bus.count_S == alarm_s_q) && (bus.count_M == alarm_m_q) &&
                   (bus.count_H == alarm_h_q);
    end

    // State register with synchronous active-low reset to RUN and alarm 00:00:10.
    always_ff @(posedge Clk_50MHz) begin
        if (!Reset_N) begin
            mode_q     <= MODE_RUN;
            field_q    <= FIELD_SEC;
            alarm_s_q  <= 6'd10;
            alarm_m_q  <= 6'd0;
            alarm_h_q  <= 5'd0;
            alarm_en_q <= 1'b0;
            idle_q     <= '0;
            add_q      <= 3'b000;
            sub_q      <= 3'b000;
            run_en_q   <= 1'b1;
            match_q    <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            field_q    <= field_d;
            alarm_s_q  <= alarm_s_d;
            alarm_m_q  <= alarm_m_d;
            alarm_h_q  <= alarm_h_d;
            alarm_en_q <= alarm_en_d;
            idle_q     <= idle_d;
            add_q      <= add_d;
            sub_q      <= sub_d;
            run_en_q   <= run_en_d;
            match_q    <= match_d;
        end
    end

    assign bus.Add_S       = add_q[0];
    assign bus.Add_M       = add_q[1];
    assign bus.Add_H       = add_q[2];
    assign bus.Subtract_S  = sub_q[0];
    assign bus.Subtract_M  = sub_q[1];
    assign bus.Subtract_H  = sub_q[2];
    assign bus.Run_en      = run_en_q;
    assign bus.Mode        = mode_q;
    assign bus.Field       = field_q;
    assign bus.Alarm_S     = alarm_s_q;
    assign bus.Alarm_M     = alarm_m_q;
    assign bus.Alarm_H     = alarm_h_q;
    assign bus.Alarm_en    = alarm_en_q;
    assign bus.Alarm_match = match_q;

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 500_000_000, meaning idle cycles before an edit mode auto-exits (10 s at 50 MHz).
REQ-002 SHALL have port Clk_50MHz  input  1  the single clock; every register updates on its rising edge.
REQ-003 SHALL have port Reset_N  input  1  synchronous, active-low reset, sampled on the Clk_50MHz rising edge.
REQ-004 SHALL have port Key_pulse  input  4  debounced one-cycle key strobes: [0] MODE, [1] SELECT, [2] UP, [3] DOWN.
REQ-005 SHALL have ports count_S, count_M, count_H  input  6/6/5  current seconds/minutes/hours, binary.
REQ-006 SHALL have ports Add_S, Add_M, Add_H  output  1 each  one-cycle increment strobes to the sec/min/hour counters.
REQ-007 SHALL have ports Subtract_S, Subtract_M, Subtract_H  output  1 each  one-cycle decrement strobes.
REQ-008 SHALL have port Run_en  output  1  high when timekeeping runs; low freezes the seconds chain.
REQ-009 SHALL have ports Mode  output  2  (0 RUN, 1 SET_TIME, 2 SET_ALARM) and Field  output  2  (0 SEC, 1 MIN, 2 HOUR), for display blinking.
REQ-010 SHALL have ports Alarm_S, Alarm_M, Alarm_H  output  6/6/5  stored alarm time, binary.
REQ-011 SHALL have ports Alarm_en  output  1 (alarm armed) and Alarm_match  output  1 (buzzer trigger level).

Function
REQ-012 SHALL implement a state machine with states RUN, SET_TIME, SET_ALARM.
REQ-013 SHALL advance on MODE: RUN->SET_TIME->SET_ALARM->RUN; each transition SHALL set Field to SEC.
REQ-014 SHALL advance Field on SELECT in SET_TIME/SET_ALARM: SEC->MIN->HOUR->SEC.
REQ-015 SHALL toggle Alarm_en on SELECT in RUN.
REQ-016 SHALL ignore UP/DOWN in RUN.
REQ-017 SHALL, in SET_TIME, answer UP (DOWN) with exactly one cycle of the Add_x (Subtract_x) strobe for the selected field, one cycle after the key strobe.
REQ-018 SHALL hold all Add/Subtract outputs low in every other case.
REQ-019 SHALL, in SET_ALARM, increment the selected alarm field on UP and decrement it on DOWN, visible the next cycle.
REQ-020 SHALL wrap alarm fields: seconds/minutes 59->0 and 0->59; hours 23->0 and 0->23.
REQ-021 SHALL drive Run_en=0 in SET_TIME and Run_en=1 in RUN and SET_ALARM.
REQ-022 SHALL resolve simultaneous keys by priority MODE > SELECT > UP > DOWN; lower-priority strobes in the same cycle are discarded.
REQ-023 SHALL clear the idle counter on any key strobe and increment it otherwise while in SET_TIME/SET_ALARM; the counter is held at 0 in RUN.
REQ-024 SHALL move to RUN with Field=SEC on the cycle after the idle counter reaches TIMEOUT_CYC-1 with no key; a key in that same cycle takes priority and clears the counter.
REQ-025 SHALL register Alarm_match, one cycle latency: high when Alarm_en=1, Mode!=SET_ALARM, and all three counts equal the alarm fields; otherwise low.
REQ-026 SHALL update Mode, Field, Alarm_* and Alarm_en only on clock edges; all outputs SHALL be registered.

Reset
REQ-027 SHALL, while Reset_N=0 at a clock edge, force: Mode=RUN, Field=SEC, Run_en=1, all Add/Subtract outputs 0, idle counter 0, Alarm_en=0, Alarm_match=0, alarm time 00:00:10 (Alarm_S=10, Alarm_M=0, Alarm_H=0).
REQ-028 SHALL let reset asserted mid-edit abort the edit, with no strobe emitted in that cycle or the next.

Verification
REQ-029 SHALL cover: reset, then MODE, then UP -> Mode=1, Run_en=0, Add_S high exactly one cycle, one cycle after the UP strobe.
REQ-030 SHALL cover: SET_ALARM with Field=HOUR, Alarm_H=23, then UP -> Alarm_H=0; DOWN -> Alarm_H=23.
REQ-031 SHALL cover: SET_ALARM with Field=SEC, Alarm_S=0, then DOWN -> Alarm_S=59, Alarm_M unchanged.
REQ-032 SHALL cover: MODE and UP in the same cycle while in RUN -> Mode=1 and no Add strobe.
REQ-033 SHALL cover: TIMEOUT_CYC=16 in SET_TIME with no keys -> Mode=RUN, Run_en=1 after the 16th idle cycle; a key at cycle 15 delays exit by 16 cycles.
REQ-034 SHALL cover: Alarm_en=1, alarm 00:00:10, count_S stepping 9->10->11 -> Alarm_match high exactly while count_S=10, delayed one cycle; low when Alarm_en=0.
